// File: rtl/codificador_instrucao.sv
// RV32I-subset encoder (lh, sh, add, sub, and, or, andi, slli, bne) with a valid/ready request port and an output FIFO of {word, address}.
// Optional ENCODER_IMM_CHECK_EN: out-of-range immediates are rejected with erro instead of being truncated.
module codificador_instrucao #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [3:0]                   req_op,
  input  logic [4:0]                   req_rd,
  input  logic [4:0]                   req_rs1,
  input  logic [4:0]                   req_rs2,
  input  logic [12:0]                  req_imm,
  output logic                         instr_valid,
  input  logic                         instr_ready,
  output logic [31:0]                  instr_data,
  output logic [ADDR_W-1:0]            instr_addr,
  output logic [$clog2(DEPTH+1)-1:0]   ocupacao,
  output logic                         erro
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

  localparam logic [3:0] OP_LH   = 4'd0;
  localparam logic [3:0] OP_SH   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_ANDI = 4'd6;
  localparam logic [3:0] OP_SLLI = 4'd7;
  localparam logic [3:0] OP_BNE  = 4'd8;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic [31:0]       r_mem_data [DEPTH];
  logic [ADDR_W-1:0] r_mem_addr [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [ADDR_W-1:0] r_addr_cnt;
  logic [31:0]       r_last_data;
  logic [ADDR_W-1:0] r_last_addr;
  logic              r_erro;

  logic [31:0] w_word;
  logic        w_op_ok;
  logic        w_imm_ok;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;

  always_comb begin
    w_word  = '0;
    w_op_ok = 1'b1;
    case (req_op)
      OP_LH:   w_word = {req_imm[11:0], req_rs1, 3'b001, req_rd, OPC_LOAD};
      OP_SH:   w_word = {req_imm[11:5], req_rs2, req_rs1, 3'b001, req_imm[4:0], OPC_STORE};
      OP_ADD:  w_word = {7'b0000000, req_rs2, req_rs1, 3'b000, req_rd, OPC_OP};
      OP_SUB:  w_word = {7'b0100000, req_rs2, req_rs1, 3'b000, req_rd, OPC_OP};
      OP_AND:  w_word = {7'b0000000, req_rs2, req_rs1, 3'b111, req_rd, OPC_OP};
      OP_OR:   w_word = {7'b0000000, req_rs2, req_rs1, 3'b110, req_rd, OPC_OP};
      OP_ANDI: w_word = {req_imm[11:0], req_rs1, 3'b111, req_rd, OPC_OP_IMM};
      OP_SLLI: w_word = {7'b0000000, req_imm[4:0], req_rs1, 3'b001, req_rd, OPC_OP_IMM};
      OP_BNE:  w_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, 3'b001,
                         req_imm[4:1], req_imm[11], OPC_BRANCH};
      default: w_op_ok = 1'b0;
    endcase
  end

`ifdef ENCODER_IMM_CHECK_EN
  always_comb begin
    w_imm_ok = 1'b1;
    case (req_op)
      OP_LH, OP_SH, OP_ANDI: w_imm_ok = (req_imm[12] == req_imm[11]);
      OP_SLLI:               w_imm_ok = (req_imm[12:5] == 8'd0);
      OP_BNE:                w_imm_ok = !req_imm[0];
      default:               w_imm_ok = 1'b1;
    endcase
  end
`else
  // Branch offsets are halfword-aligned, so bit 0 never reaches the word.
  logic w_unused_imm0;
  assign w_unused_imm0 = req_imm[0];
  assign w_imm_ok      = 1'b1;
`endif

  assign req_ready = (r_count != C_FULL);
  assign w_accept  = req_valid && req_ready;
  assign w_push    = w_accept && w_op_ok && w_imm_ok;
  assign w_pop     = instr_valid && instr_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_addr[i] <= '0;
      end
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_addr_cnt  <= '0;
      r_last_data <= '0;
      r_last_addr <= '0;
      r_erro      <= 1'b0;
    end else begin
      r_erro <= w_accept && !(w_op_ok && w_imm_ok);
      if (w_push) begin
        r_mem_data[r_wr_ptr] <= w_word;
        r_mem_addr[r_wr_ptr] <= r_addr_cnt;
        r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
        r_addr_cnt           <= r_addr_cnt + ADDR_W'(1);
      end
      // Popped head is kept so the outputs hold their last value once empty.
      if (w_pop) begin
        r_last_data <= r_mem_data[r_rd_ptr];
        r_last_addr <= r_mem_addr[r_rd_ptr];
        r_rd_ptr    <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign instr_valid = (r_count != '0);
  assign instr_data  = instr_valid ? r_mem_data[r_rd_ptr] : r_last_data;
  assign instr_addr  = instr_valid ? r_mem_addr[r_rd_ptr] : r_last_addr;
  assign ocupacao    = r_count;
  assign erro        = r_erro;

endmodule

// File: tb/tb_codificador_instrucao.sv
// Scoreboard bench for codificador_instrucao: driver queues expected {addr, word}, a negedge monitor checks pops and status.
module tb_codificador_instrucao;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [4:0]  req_rd = '0, req_rs1 = '0, req_rs2 = '0;
  logic [12:0] req_imm = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_data;
  logic [ADDR_W-1:0] instr_addr;
  logic [2:0]  ocupacao;
  logic        erro;

  codificador_instrucao #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_addr(instr_addr),
    .ocupacao(ocupacao), .erro(erro)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  logic [39:0] sb[$];
  logic [7:0]  addr_m    = 8'd0;
  logic [31:0] last_data = 32'd0;
  logic        pend_acc  = 1'b0;
  logic        pend_ok   = 1'b0;
  logic [31:0] pend_word = 32'd0;
  logic        exp_erro  = 1'b0;
  logic        in_reset  = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder built from the instruction field layout with plain arithmetic.
  function automatic logic [32:0] model(input int op, input int rd, input int rs1,
                                        input int rs2, input int imm);
    int unsigned opc[9] = '{3, 35, 51, 51, 51, 51, 19, 19, 99};
    int unsigned f3[9]  = '{1, 1, 0, 0, 7, 6, 7, 1, 1};
    int unsigned w;
    int          s;
    bit          ok;
    if (op > 8) return 33'd0;
    ok = 1'b1;
    s  = (imm >= 4096) ? imm - 8192 : imm;
    w  = opc[op] + (f3[op] << 12) + (rs1 << 15);
    case (op)
      0, 6: w += (rd << 7) + ((imm % 4096) << 20);
      1:    w += ((imm % 32) << 7) + (rs2 << 20) + (((imm / 32) % 128) << 25);
      7:    w += (rd << 7) + ((imm % 32) << 20);
      8:    w += (((imm / 2048) % 2) << 7) + (((imm / 2) % 16) << 8) + (rs2 << 20)
                 + (((imm / 32) % 64) << 25) + (((imm / 4096) % 2) << 31);
      default: w += (rd << 7) + (rs2 << 20) + ((op == 3) ? (32 << 25) : 0);
    endcase
`ifdef ENCODER_IMM_CHECK_EN
    if (op == 0 || op == 1 || op == 6) ok = (s >= -2048) && (s <= 2047);
    if (op == 7) ok = (imm < 32);
    if (op == 8) ok = (imm % 2 == 0);
`endif
    return {ok, w};
  endfunction

  task automatic commit();
    exp_erro = pend_acc && !pend_ok;
    if (pend_acc && pend_ok) begin
      sb.push_back({addr_m, pend_word});
      addr_m++;
    end
    pend_acc = 1'b0;
  endtask

  task automatic drive(input logic v, input int op, input int rd, input int rs1, input int rs2,
                       input int imm, input logic rdy, input bit directed, input logic [32:0] dexp);
    logic [32:0] m;
    @(posedge clk); #2;
    commit();
    req_valid   = v;
    req_op      = 4'(op);
    req_rd      = 5'(rd);
    req_rs1     = 5'(rs1);
    req_rs2     = 5'(rs2);
    req_imm     = 13'(imm);
    instr_ready = rdy;
    m = directed ? dexp : model(op, rd, rs1, rs2, imm);
    pend_acc  = v && (sb.size() != DEPTH);
    pend_ok   = m[32];
    pend_word = m[31:0];
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 0, 0, 0, 0, 0, rdy, 1'b0, 33'd0);
  endtask

  task automatic rand_req(input int ready_pct);
    int imm;
    imm = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 8191))
                                       : int'($urandom_range(0, 31)) * 2;
    drive($urandom_range(0, 9) < 8, $urandom_range(0, 15), $urandom_range(0, 31),
          $urandom_range(0, 31), $urandom_range(0, 31), imm,
          $urandom_range(0, 99) < ready_pct, 1'b0, 33'd0);
  endtask

  always @(negedge clk) begin
    if (!in_reset) begin
      chk("ocupacao", 32'(ocupacao), 32'(sb.size()));
      chk("req_ready", 32'(req_ready), 32'(sb.size() != DEPTH));
      chk("instr_valid", 32'(instr_valid), 32'(sb.size() != 0));
      chk("erro", 32'(erro), 32'(exp_erro));
      if (sb.size() == 0) begin
        chk("hold_data", instr_data, last_data);
      end else if (instr_ready) begin
        chk("instr_data", instr_data, sb[0][31:0]);
        chk("instr_addr", 32'(instr_addr), 32'(sb[0][39:32]));
        last_data = sb[0][31:0];
        void'(sb.pop_front());
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #2;
    in_reset  = 1'b1;
    reset     = 1'b1;
    req_valid = 1'b0;
    #1;
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_ocupacao", 32'(ocupacao), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    sb.delete();
    addr_m    = 8'd0;
    last_data = 32'd0;
    pend_acc  = 1'b0;
    exp_erro  = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset    = 1'b0;
    in_reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_instr_valid", 32'(instr_valid), 32'd0);
    chk("reset_instr_data", instr_data, 32'd0);
    chk("reset_instr_addr", 32'(instr_addr), 32'd0);
    chk("reset_ocupacao", 32'(ocupacao), 32'd0);
    chk("reset_erro", 32'(erro), 32'd0);
    reset    = 1'b0;
    in_reset = 1'b0;

    // Invalid op, then the directed encodings; the first valid word must land at address 0.
    drive(1'b1, 12, 1, 2, 3, 0, 1'b1, 1'b0, 33'd0);
    drive(1'b1, 2, 3, 1, 2, 0, 1'b1, 1'b1, {1'b1, 32'h002081B3});
    drive(1'b1, 0, 5, 6, 0, 4, 1'b1, 1'b1, {1'b1, 32'h00431283});
    drive(1'b1, 1, 0, 6, 7, 8, 1'b1, 1'b1, {1'b1, 32'h00731423});
    drive(1'b1, 8, 0, 1, 2, 13'h1FFC, 1'b1, 1'b1, {1'b1, 32'hFE209EE3});
`ifdef ENCODER_IMM_CHECK_EN
    drive(1'b1, 6, 0, 0, 0, 13'h0800, 1'b1, 1'b1, 33'd0);
`else
    drive(1'b1, 6, 0, 0, 0, 13'h0800, 1'b1, 1'b1, {1'b1, 32'h80007013});
`endif
    idle(1'b1, 4);

    // Fill to DEPTH with the consumer stalled, try a fifth, then drain.
    for (int k = 0; k < 5; k++) drive(1'b1, 2 + (k % 4), k, k + 1, k + 2, 0, 1'b0, 1'b0, 33'd0);
    idle(1'b0, 3);
    idle(1'b1, 6);

    for (int k = 0; k < 1200; k++) rand_req(75);
    idle(1'b1, 6);

    for (int k = 0; k < 3; k++) drive(1'b1, 4, k, 2, 3, 0, 1'b0, 1'b0, 33'd0);
    do_reset();
    for (int k = 0; k < 200; k++) rand_req(60);
    idle(1'b1, 8);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
